// File: rtl/soi_trace_stream.sv
// soi_trace_stream
// Observes a signal-of-interest probe and records every value change, together
// with a free-running cycle timestamp, into a first-word-fall-through FIFO that
// drains to a host-side reader over a valid/ready stream.
// Optional feature: define SOI_TRACE_DROP_CNT_EN to add the saturating 16-bit
// drop_cnt output; without it, overflow is the only loss indication.

module soi_trace_stream #(
    parameter int WIDTH    = 1,
    parameter int TS_WIDTH = 32,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         probe,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_value,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow
`ifdef SOI_TRACE_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = WIDTH + TS_WIDTH;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Observation state
    logic [TS_WIDTH-1:0] ts_r;
    logic [WIDTH-1:0]    prev_r;
    logic                en_d_r;

    // FIFO state
    logic [RW-1:0]       mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [LW-1:0]       level_r;
    logic [LW-1:0]       level_nxt_s;
    logic                out_valid_r;
    logic                overflow_r;

    // Per-edge decisions
    logic                event_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;

    // Decide event, pop, push and drop for the coming edge
    always_comb begin
        event_s = 1'b0;
        pop_s   = 1'b0;
        push_s  = 1'b0;
        drop_s  = 1'b0;
        if (en && (!en_d_r || (probe != prev_r))) begin
            event_s = 1'b1;
        end else begin
            event_s = 1'b0;
        end
        pop_s = out_valid_r & out_ready;
        // A full FIFO still accepts a record when the head leaves at the same edge
        if (event_s && ((level_r != FULL_LEVEL) || pop_s)) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else if (event_s) begin
            push_s = 1'b0;
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Next occupancy from the push/pop combination
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1'b1);
            2'b01:   level_nxt_s = level_r - LW'(1'b1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Free-running timestamp, previous-value and enable-delay registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r   <= '0;
            prev_r <= '0;
            en_d_r <= 1'b0;
        end else begin
            ts_r   <= ts_r + TS_WIDTH'(1'b1);
            prev_r <= probe;
            en_d_r <= en;
        end
    end

    // Record storage; contents are meaningless until covered by level
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {probe, ts_r};
        end
    end

    // Pointers, occupancy and registered valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            level_r     <= level_nxt_s;
            out_valid_r <= (level_nxt_s != '0);
        end
    end

    // Sticky loss flag; a drop wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_overflow) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef SOI_TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating drop counter; a clear coinciding with a drop restarts at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && clr_overflow) begin
            drop_cnt_r <= 16'd1;
        end else if (drop_s) begin
            if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end else if (clr_overflow) begin
            drop_cnt_r <= 16'd0;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign out_valid               = out_valid_r;
    assign level                   = level_r;
    assign overflow                = overflow_r;
    assign {out_value, out_ts}     = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_soi_trace_stream.sv
// Self-checking bench for soi_trace_stream (WIDTH=8, TS_WIDTH=4, DEPTH=4).
// A queue-based reference model tracks the recorded stream, occupancy and loss
// indications; directed scenarios are followed by randomized traffic.

module tb_soi_trace_stream;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int D  = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  probe;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_value;
    logic [TW-1:0] out_ts;
    logic [2:0]    level;
    logic          overflow;
    logic          clr_overflow;
`ifdef SOI_TRACE_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    soi_trace_stream #(.WIDTH(W), .TS_WIDTH(TW), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .probe        (probe),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_ts       (out_ts),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef SOI_TRACE_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  v;
        logic [TW-1:0] t;
    } rec_t;

    rec_t      q[$];
    int        m_ts;
    logic [W-1:0] m_prev;
    logic      m_en_d;
    logic      m_ovf;
    int        m_drop;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts   = 0;
        m_prev = '0;
        m_en_d = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic compare();
        check("level", 32'(level), 32'(q.size()));
        check("valid", 32'(out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SOI_TRACE_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        if (q.size() != 0) begin
            check("head_value", 32'(out_value), 32'(q[0].v));
            check("head_ts", 32'(out_ts), 32'(q[0].t));
        end
    endtask

    // One clock edge: model the rules on the values present before the edge
    task automatic cycle();
        logic [W-1:0] pv;
        logic pe, pc, ev, pop, dropped;
        rec_t r;
        pv  = probe;
        pe  = en;
        pc  = clr_overflow;
        ev  = pe && (!m_en_d || (pv != m_prev));
        pop = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        dropped = 1'b0;
        if (ev) begin
            if (q.size() < D) begin
                r.v = pv;
                r.t = TW'(m_ts);
                q.push_back(r);
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (pc) m_ovf = 1'b0;
        if (dropped) m_drop = pc ? 1 : ((m_drop < 65535) ? m_drop + 1 : m_drop);
        else if (pc) m_drop = 0;
        m_prev = pv;
        m_en_d = pe;
        m_ts   = (m_ts + 1) % (1 << TW);
        #1;
        compare();
    endtask

    initial begin
        logic [3:0] wrap_exp [3];
        rst_n = 1'b0;
        en = 1'b0;
        probe = '0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        model_reset();
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
`ifdef SOI_TRACE_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Baseline record when en rises with a static probe
        while (m_ts != 5) cycle();
        en = 1'b1;
        cycle();
        check("base_level", 32'(level), 32'd1);
        check("base_value", 32'(out_value), 32'd0);
        check("base_ts", 32'(out_ts), 32'd5);
        repeat (3) cycle();
        check("base_static", 32'(level), 32'd1);

        // Change stream: repeated value produces no record
        out_ready = 1'b1;
        while (m_ts != 10) cycle();
        probe = 8'h11; cycle();
        check("chg_first_value", 32'(out_value), 32'h11);
        check("chg_first_ts", 32'(out_ts), 32'd10);
        probe = 8'h22; cycle();
        probe = 8'h22; cycle();
        check("chg_no_repeat", 32'(level), 32'd0);
        probe = 8'h33; cycle();
        check("chg_third_ts", 32'(out_ts), 32'd13);

        // Backpressure until full, then drops
        repeat (3) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            probe = probe ^ 8'hFF;
            cycle();
        end
        check("full_level", 32'(level), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_head", 32'(out_value), 32'h33 ^ 32'hFF);
`ifdef SOI_TRACE_DROP_CNT_EN
        check("full_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        // Full with concurrent pop: push accepted
        out_ready = 1'b1;
        probe = probe ^ 8'hFF;
        cycle();
        check("fullpop_level", 32'(level), 32'd4);
        check("fullpop_overflow", 32'(overflow), 32'd1);
        check("fullpop_head", 32'(out_value), 32'h33);
        // Clear with a drop at the same edge: set wins
        out_ready = 1'b0;
        clr_overflow = 1'b1;
        probe = probe ^ 8'hFF;
        cycle();
        check("clr_vs_drop", 32'(overflow), 32'd1);
        probe = probe ^ 8'hFF;
        cycle();
        clr_overflow = 1'b0;
        probe = probe ^ 8'hFF;
        cycle();
        check("clr_pending_drop", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);

        // Timestamp wrap 14, 15, 0
        out_ready = 1'b1;
        repeat (6) cycle();
        while (m_ts != 14) cycle();
        wrap_exp[0] = 4'd14; wrap_exp[1] = 4'd15; wrap_exp[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            probe = probe + 8'd1;
            cycle();
            check("wrap_ts", 32'(out_ts), 32'(wrap_exp[i]));
        end

        // Async reset mid-stream with three queued records
        repeat (2) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            probe = probe + 8'd3;
            cycle();
        end
        check("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_level", 32'(level), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle();
        check("post_rst_empty", 32'(level), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            en           = ($urandom_range(0, 9) != 0);
            probe        = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : probe;
            out_ready    = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            clr_overflow = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
